// File: rtl/window_pkg.sv
// Shared types and helpers for the window multiplier: FSM state encoding,
// symmetric half-table addressing, Q1.x constants and saturation.
package window_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Fold a frame position onto the symmetric half table.
    function automatic int mirror_addr(input int pos, input int frame_size);
        if (pos < (frame_size / 2)) begin
            return pos;
        end else begin
            return frame_size - 1 - pos;
        end
    endfunction

    // Unity gain in Q1.(w-1).
    function automatic int unsigned coef_one(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Half an LSB of the Q1.(w-1) product, added before the right shift.
    function automatic int unsigned round_bias(input int w);
        return 32'd1 << (w - 2);
    endfunction

    // Clamp a signed value to the range of a signed width-bit number.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/window_coeff_ram.sv
// Half-frame coefficient store: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module window_coeff_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/window_engine.sv
// Streaming window multiplier: loadable symmetric coefficient table applied to
// channel-interleaved samples, with Q1.x rounding, saturation and frame tags.
// Two pipeline stages: S1 (table read + tags), S2 (multiply/round/saturate).
module window_engine
    import window_pkg::*;
#(
    parameter int FRAME_SIZE   = 256,
    parameter int SAMPLE_WIDTH = 16,
    parameter int COEFF_WIDTH  = 16,
    parameter int NUM_CHANNELS = 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  s_valid,
    output logic                                                  s_ready,
    input  logic [SAMPLE_WIDTH-1:0]                               s_data,
    input  logic                                                  frame_restart,
    input  logic                                                  bypass,
    input  logic                                                  coef_we,
    input  logic [$clog2(FRAME_SIZE/2)-1:0]                       coef_addr,
    input  logic [COEFF_WIDTH-1:0]                                coef_wdata,
    output logic                                                  m_valid,
    input  logic                                                  m_ready,
    output logic [SAMPLE_WIDTH-1:0]                               m_data,
    output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] m_chan,
    output logic                                                  m_first,
    output logic                                                  m_last,
    output logic                                                  init_done
);

    localparam int HALF   = FRAME_SIZE / 2;
    localparam int AW     = $clog2(HALF);
    localparam int PW     = $clog2(FRAME_SIZE);
    localparam int CHW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PROD_W = SAMPLE_WIDTH + COEFF_WIDTH + 1;

    localparam logic [COEFF_WIDTH-1:0]   COEF_ONE = COEFF_WIDTH'(coef_one(COEFF_WIDTH));
    localparam logic signed [PROD_W-1:0] ROUND    = PROD_W'(round_bias(COEFF_WIDTH));

    state_t                    state_r;
    logic [AW-1:0]             init_addr_r;
    logic                      accept_en_r;
    logic [PW-1:0]             pos_r;
    logic [CHW-1:0]            chan_r;

    logic                      s1_valid_r;
    logic signed [SAMPLE_WIDTH-1:0] s1_data_r;
    logic [CHW-1:0]            s1_chan_r;
    logic                      s1_first_r;
    logic                      s1_last_r;
    logic                      s1_bypass_r;

    logic                      s2_adv_s;
    logic                      s1_adv_s;
    logic                      accept_s;
    logic [PW-1:0]             tag_pos_s;
    logic [CHW-1:0]            tag_chan_s;
    logic [PW-1:0]             next_pos_s;
    logic [CHW-1:0]            next_chan_s;
    logic [AW-1:0]             rd_addr_s;
    logic                      ram_we_s;
    logic [AW-1:0]             ram_waddr_s;
    logic [COEFF_WIDTH-1:0]    ram_wdata_s;
    logic [COEFF_WIDTH-1:0]    ram_rdata_s;
    logic [COEFF_WIDTH-1:0]    coef_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [PROD_W-1:0]  sum_s;
    logic signed [PROD_W-1:0]  rnd_s;

    // Handshake: each stage advances when it is empty or its output is taken.
    always_comb begin
        s2_adv_s = !m_valid || m_ready;
        s1_adv_s = !s1_valid_r || s2_adv_s;
        s_ready  = accept_en_r && s1_adv_s;
        accept_s = s_valid && s_ready;
    end

    // Tag for the sample being offered and the counter values that follow it.
    always_comb begin
        if (frame_restart) begin
            tag_pos_s  = '0;
            tag_chan_s = '0;
        end else begin
            tag_pos_s  = pos_r;
            tag_chan_s = chan_r;
        end
        if (tag_chan_s == CHW'(NUM_CHANNELS - 1)) begin
            next_chan_s = '0;
            next_pos_s  = tag_pos_s + PW'(1);
        end else begin
            next_chan_s = tag_chan_s + CHW'(1);
            next_pos_s  = tag_pos_s;
        end
        rd_addr_s = AW'(mirror_addr(int'(tag_pos_s), FRAME_SIZE));
    end

    // Table write port: INIT fills unity gain, RUN takes user writes.
    always_comb begin
        if (state_r == INIT) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = init_addr_r;
            ram_wdata_s = COEF_ONE;
        end else begin
            ram_we_s    = coef_we;
            ram_waddr_s = coef_addr;
            ram_wdata_s = coef_wdata;
        end
    end

    window_coeff_ram #(
        .DEPTH (HALF),
        .WIDTH (COEFF_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (accept_s),
        .raddr (rd_addr_s),
        .rdata (ram_rdata_s)
    );

    // S2 arithmetic: signed sample times unsigned coefficient, round half up.
    always_comb begin
        if (s1_bypass_r) begin
            coef_s = COEF_ONE;
        end else begin
            coef_s = ram_rdata_s;
        end
        prod_s = PROD_W'(s1_data_r) * PROD_W'($signed({1'b0, coef_s}));
        sum_s  = prod_s + ROUND;
        rnd_s  = sum_s >>> (COEFF_WIDTH - 1);
    end

    // Control FSM: table initialisation, then run; input enable lags init_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= INIT;
            init_addr_r <= '0;
            init_done   <= 1'b0;
            accept_en_r <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    init_addr_r <= init_addr_r + AW'(1);
                    if (init_addr_r == AW'(HALF - 1)) begin
                        state_r   <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    accept_en_r <= 1'b1;
                end
                default: begin
                    state_r <= INIT;
                end
            endcase
        end
    end

    // Position/channel counters; frame_restart realigns them to the frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_r  <= '0;
            chan_r <= '0;
        end else if (accept_s) begin
            pos_r  <= next_pos_s;
            chan_r <= next_chan_s;
        end else if (frame_restart) begin
            pos_r  <= '0;
            chan_r <= '0;
        end
    end

    // Stage 1: capture the accepted sample with its tags and bypass flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_data_r   <= '0;
            s1_chan_r   <= '0;
            s1_first_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s1_bypass_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_data_r   <= $signed(s_data);
                s1_chan_r   <= tag_chan_s;
                s1_first_r  <= (tag_pos_s == '0) && (tag_chan_s == '0);
                s1_last_r   <= (tag_pos_s == PW'(FRAME_SIZE - 1)) &&
                               (tag_chan_s == CHW'(NUM_CHANNELS - 1));
                s1_bypass_r <= bypass;
            end
        end
    end

    // Stage 2: registered outputs, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
        end else if (s2_adv_s) begin
            m_valid <= s1_valid_r;
            if (s1_valid_r) begin
                m_data  <= SAMPLE_WIDTH'(sat(64'(rnd_s), SAMPLE_WIDTH));
                m_chan  <= s1_chan_r;
                m_first <= s1_first_r;
                m_last  <= s1_last_r;
            end
        end
    end

endmodule

// File: tb/tb_window_engine.sv
// Directed, table-driven bench for window_engine (8-sample frames, 2 channels).
module tb_window_engine;

    localparam int FS = 8;
    localparam int NC = 2;
    localparam int SW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [SW-1:0] s_data;
    logic          frame_restart;
    logic          bypass;
    logic          coef_we;
    logic [1:0]    coef_addr;
    logic [CW-1:0] coef_wdata;
    logic          m_valid;
    logic          m_ready;
    logic [SW-1:0] m_data;
    logic [0:0]    m_chan;
    logic          m_first;
    logic          m_last;
    logic          init_done;

    always #5 clk = ~clk;

    window_engine #(
        .FRAME_SIZE   (FS),
        .SAMPLE_WIDTH (SW),
        .COEFF_WIDTH  (CW),
        .NUM_CHANNELS (NC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .frame_restart (frame_restart),
        .bypass        (bypass),
        .coef_we       (coef_we),
        .coef_addr     (coef_addr),
        .coef_wdata    (coef_wdata),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_chan        (m_chan),
        .m_first       (m_first),
        .m_last        (m_last),
        .init_done     (init_done)
    );

    typedef struct {
        logic signed [15:0] din;
        logic               byp;
        logic               restart;
        logic               we;
        logic [1:0]         waddr;
        logic [15:0]        wdata;
        logic signed [15:0] exp_data;
        logic               exp_chan;
        logic               exp_first;
        logic               exp_last;
    } vec_t;

    vec_t vecs [16];
    int   checks = 0;
    int   errors = 0;

    // Mirrored table {0,0x2000,0x4000,0x8000} applied to 0x4000, per position.
    int ref_b [8] = '{0, 4096, 8192, 16384, 16384, 8192, 4096, 0};
    int c_din [8] = '{32767, -32768, -1, 1, 12345, -12345, 0, -500};
    int d_in  [16] = '{28672, -28672, 3, -3, 5, -5, 32767, -32768,
                       100, -1, 1, -1, 7, -7, -32768, 16384};
    int d_exp [16] = '{32767, -32768, 2, -1, 3, -2, 32767, -32768,
                       100, -1, 1, 0, 4, -3, -32768, 32767};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input int din, input bit byp, input bit restart,
                       input int exp_data, input bit chan, input bit first, input bit last);
        vecs[i].din       = 16'(din);
        vecs[i].byp       = byp;
        vecs[i].restart   = restart;
        vecs[i].we        = 1'b0;
        vecs[i].waddr     = 2'd0;
        vecs[i].wdata     = 16'd0;
        vecs[i].exp_data  = 16'(exp_data);
        vecs[i].exp_chan  = chan;
        vecs[i].exp_first = first;
        vecs[i].exp_last  = last;
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we    = 1'b1;
        coef_addr  = 2'(a);
        coef_wdata = 16'(d);
        step;
        coef_we    = 1'b0;
    endtask

    // Reset, then watch INIT: s_ready low, init_done after 4 cycles, coef_we ignored.
    task automatic init_seq(input string tag);
        rst = 1'b1; s_valid = 1'b1; s_data = 16'd1000; bypass = 1'b0; frame_restart = 1'b0;
        coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 16'd0; m_ready = 1'b1;
        step;
        chk({tag, "_rst_m_valid"}, int'(m_valid), 0);
        chk({tag, "_rst_s_ready"}, int'(s_ready), 0);
        chk({tag, "_rst_init_done"}, int'(init_done), 0);
        chk({tag, "_rst_m_data"}, int'(m_data), 0);
        chk({tag, "_rst_tags"}, int'({m_chan, m_first, m_last}), 0);
        step;
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step;
            chk($sformatf("%s_init%0d_s_ready", tag, k), int'(s_ready), 0);
            chk($sformatf("%s_init%0d_done", tag, k), int'(init_done), (k == 4) ? 1 : 0);
        end
        s_valid = 1'b0;
        coef_we = 1'b0;
        step;
        chk({tag, "_run_s_ready"}, int'(s_ready), 1);
    endtask

    // Drive vecs[0..n-1] with optional downstream stalls and compare outputs in order.
    task automatic run_stream(input string tag, input int n, input bit stall);
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        int   first_acc = -1;
        int   first_out = -1;
        bit   held = 1'b0;
        bit   wrote = 1'b0;
        bit   acc;
        int   h_data;
        int   h_tags;
        while ((got < n) && (cyc < 400)) begin
            if (sent < n) begin
                s_valid       = 1'b1;
                s_data        = vecs[sent].din;
                bypass        = vecs[sent].byp;
                frame_restart = vecs[sent].restart;
                coef_we       = vecs[sent].we && !wrote;
                coef_addr     = vecs[sent].waddr;
                coef_wdata    = vecs[sent].wdata;
            end else begin
                s_valid       = 1'b0;
                bypass        = 1'b0;
                frame_restart = 1'b0;
                coef_we       = 1'b0;
            end
            m_ready = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
            @(negedge clk);
            if (held) begin
                chk($sformatf("%s_hold_valid", tag), int'(m_valid), 1);
                chk($sformatf("%s_hold_data", tag), int'($signed(m_data)), h_data);
                chk($sformatf("%s_hold_tags", tag), int'({m_chan, m_first, m_last}), h_tags);
            end
            held   = m_valid && !m_ready;
            h_data = int'($signed(m_data));
            h_tags = int'({m_chan, m_first, m_last});
            if (m_valid && m_ready) begin
                if (got < n) begin
                    chk($sformatf("%s[%0d]_data", tag, got), int'($signed(m_data)), int'(vecs[got].exp_data));
                    chk($sformatf("%s[%0d]_chan", tag, got), int'(m_chan), int'(vecs[got].exp_chan));
                    chk($sformatf("%s[%0d]_first", tag, got), int'(m_first), int'(vecs[got].exp_first));
                    chk($sformatf("%s[%0d]_last", tag, got), int'(m_last), int'(vecs[got].exp_last));
                end
                if (first_out < 0) first_out = cyc;
                got++;
            end
            acc = s_valid && s_ready;
            if (acc && (first_acc < 0)) first_acc = cyc;
            if (coef_we) wrote = 1'b1;
            step;
            if (acc) begin
                sent++;
                wrote = 1'b0;
            end
            cyc++;
        end
        s_valid = 1'b0; bypass = 1'b0; frame_restart = 1'b0; coef_we = 1'b0; m_ready = 1'b1;
        if (got < n) chk({tag, "_timeout_outputs"}, got, n);
        if (!stall) chk({tag, "_latency"}, first_out - first_acc, 2);
    endtask

    initial begin
        init_seq("init");

        // Unity table: 1000 passes through; tags over a full 2-channel frame.
        for (int i = 0; i < 16; i++) put(i, 1000, 1'b0, 1'b0, 1000, i[0], i == 0, i == 15);
        run_stream("unity", 16, 1'b0);

        // Symmetric table, channel pairs share a coefficient.
        write_coef(0, 0); write_coef(1, 'h2000); write_coef(2, 'h4000); write_coef(3, 'h8000);
        for (int i = 0; i < 16; i++) put(i, 'h4000, 1'b0, 1'b0, ref_b[i/2], i[0], i == 0, i == 15);
        run_stream("symm", 16, 1'b0);

        // Bypass interleaved with table samples under back-pressure.
        for (int i = 0; i < 16; i++) begin
            if (i[0] == 1'b0) put(i, c_din[i/2], 1'b1, 1'b0, c_din[i/2], 1'b0, i == 0, 1'b0);
            else              put(i, 'h4000, 1'b0, 1'b0, ref_b[i/2], 1'b1, 1'b0, i == 15);
        end
        run_stream("bypass_stall", 16, 1'b1);

        // Rounding and saturation: table {0xFFFF,0x4000,0x4000,0x8000}.
        write_coef(0, 'hFFFF); write_coef(1, 'h4000);
        for (int i = 0; i < 16; i++) put(i, d_in[i], 1'b0, 1'b0, d_exp[i], i[0], i == 0, i == 15);
        run_stream("round", 16, 1'b0);
        run_stream("round_stall", 16, 1'b1);

        // Same-cycle write/read returns old coef; frame_restart on 1st and 5th samples.
        put(0, 'h4000, 1'b0, 1'b1, 32767, 1'b0, 1'b1, 1'b0);
        vecs[0].we = 1'b1; vecs[0].waddr = 2'd0; vecs[0].wdata = 16'h2000;
        put(1, 'h4000, 1'b0, 1'b0, 4096, 1'b1, 1'b0, 1'b0);
        put(2, 'h4000, 1'b0, 1'b0, 8192, 1'b0, 1'b0, 1'b0);
        put(3, 'h4000, 1'b0, 1'b0, 8192, 1'b1, 1'b0, 1'b0);
        put(4, 'h4000, 1'b0, 1'b1, 4096, 1'b0, 1'b1, 1'b0);
        put(5, 'h4000, 1'b0, 1'b0, 4096, 1'b1, 1'b0, 1'b0);
        put(6, 'h4000, 1'b0, 1'b0, 8192, 1'b0, 1'b0, 1'b0);
        put(7, 'h4000, 1'b0, 1'b0, 8192, 1'b1, 1'b0, 1'b0);
        run_stream("restart", 8, 1'b0);

        // frame_restart with no sample offered clears the counters.
        frame_restart = 1'b1;
        step;
        frame_restart = 1'b0;
        put(0, 'h4000, 1'b0, 1'b0, 4096, 1'b0, 1'b1, 1'b0);
        run_stream("idle_restart", 1, 1'b0);

        // rst mid-stream flushes the pipeline and re-initialises the table.
        s_valid = 1'b1; s_data = 16'd1000; bypass = 1'b0; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) step;
        chk("pre_rst_m_valid", int'(m_valid), 1);
        init_seq("midrst");
        put(0, 1000, 1'b0, 1'b0, 1000, 1'b0, 1'b1, 1'b0);
        put(1, 1000, 1'b0, 1'b0, 1000, 1'b1, 1'b0, 1'b0);
        run_stream("after_rst", 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_engine.md
# window_engine

Streaming, parametrised window multiplier for the MFCC front end, the next generation of the fixed Hamming stage. It sits between the audio sample source and the framing/FFT stage. It holds a loadable, symmetric (half-frame) coefficient table, applies it to time-division-interleaved multi-channel samples with rounding and saturation, and tags frame boundaries. It uses valid/ready handshakes on both sides and supports full throughput with back-pressure.

## Interface
- FRAME_SIZE, 256, samples per channel per frame; power of two, ≥4
- SAMPLE_WIDTH, 16, signed two's-complement sample width
- COEFF_WIDTH, 16, unsigned coefficient width; Q1.(COEFF_WIDTH-1), so 1.0 = 2^(COEFF_WIDTH-1)
- NUM_CHANNELS, 1, interleaved channels (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  engine accepts sample
- s_data  in  SAMPLE_WIDTH  signed input sample
- frame_restart  in  1  force next accepted sample to position 0, channel 0
- bypass  in  1  use coefficient 1.0 (rectangular window)
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(FRAME_SIZE/2)  half-table address
- coef_wdata  in  COEFF_WIDTH  coefficient value
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts
- m_data  out  SAMPLE_WIDTH  windowed signed sample
- m_chan  out  max(1,$clog2(NUM_CHANNELS))  channel of m_data
- m_first  out  1  position 0, channel 0
- m_last  out  1  position FRAME_SIZE-1, channel NUM_CHANNELS-1
- init_done  out  1  table initialisation complete

## Operation
- States: INIT, RUN. Reset enters INIT.
- INIT writes 2^(COEFF_WIDTH-1) to addresses 0..FRAME_SIZE/2-1, one per cycle. After the last write, the FSM moves to RUN and init_done rises. s_ready is 0 in INIT. coef_we is ignored in INIT.
- RUN: a sample is accepted on s_valid && s_ready. Counters chan (0..NUM_CHANNELS-1) and pos (0..FRAME_SIZE-1) tag the sample.
- chan increments per accepted sample. When it wraps, pos increments. pos wraps from FRAME_SIZE-1 to 0.
- Mirrored address: addr = pos < FRAME_SIZE/2 ? pos : FRAME_SIZE-1-pos.
- frame_restart in a cycle with an accepted sample tags that sample pos 0, chan 0. Counters then continue from there. Without acceptance, counters clear to 0. Samples already in the pipeline are unaffected.
- Coefficient select: coef = bypass ? 2^(COEFF_WIDTH-1) : table[addr]. bypass is sampled with the sample at acceptance.
- Arithmetic:
  - p = s_data × {0,coef}, signed, width SAMPLE_WIDTH+COEFF_WIDTH+1.
  - r = (p + 2^(COEFF_WIDTH-2)) >>> (COEFF_WIDTH-1).
  - Saturate r to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
- Coef write in RUN: table[coef_addr] ← coef_wdata.
  - A read of the same address in the same cycle returns the old value.
  - The new value is visible to samples accepted from the next cycle.

## Timing
- Pipeline has two register stages: S1 (table read, tags), S2 (multiply/round/saturate, outputs).
- Latency: sample accepted in cycle t appears on m_* in cycle t+2 when there is no back-pressure.
- Each stage advances when its output is empty or taken downstream. s_ready = RUN && (!S1.valid || S2 advances).
- Throughput: one sample per cycle with m_ready held high.
- Output hold: m_data, m_chan, m_first and m_last stay stable while m_valid && !m_ready. No drops, no duplicates.
- Reset values: m_valid 0, m_data 0, m_chan 0, m_first 0, m_last 0, s_ready 0, init_done 0; pos and chan 0; pipeline empty.
- rst mid-stream flushes both stages and restarts INIT. The table is re-initialised to 1.0 and loaded coefficients are lost.
- INIT lasts FRAME_SIZE/2 cycles after rst deasserts. s_ready first goes high in the cycle after init_done rises.

## Structure
- Shared package window_pkg:
  - state enum {INIT, RUN}
  - function mirror_addr(pos)
  - localparams COEF_ONE = 2^(COEFF_WIDTH-1) and ROUND = 2^(COEFF_WIDTH-2)
  - function sat(value, width)
- Sub-module window_coeff_ram: simple dual-port, FRAME_SIZE/2 × COEFF_WIDTH, one write port, one registered read port, read-old-on-collision, no reset.
- The top level holds the FSM, counters, pipeline registers and arithmetic.

## Test plan
- Reset/INIT, FRAME_SIZE=8: release rst. Expect init_done high after 4 cycles and s_ready low until then. With bypass=0, stream s_data=1000. Expect m_data=1000 for all 8 outputs, m_first on output 0, m_last on output 7.
- Symmetry: load table 0..3 = {0x0000, 0x2000, 0x4000, 0x8000}, stream 8 samples of 0x4000. Expect m_data = {0, 0x1000, 0x2000, 0x4000, 0x4000, 0x2000, 0x1000, 0}.
- Rounding/saturation: coef 0xFFFF (≈2.0).
  - s_data=0x7000 → m_data=0x7FFF.
  - s_data=-0x7000 → m_data=-0x8000.
  - coef 0x4000 with s_data=3 → m_data=2 (1.5 rounds up); s_data=-3 → m_data=-1.
- Multi-channel, NUM_CHANNELS=2: stream 16 samples. Expect m_chan alternating 0/1, m_first only on output 0, m_last only on output 15, and channel pairs windowed by the same coefficient.
- Back-pressure: random m_ready at 30% with continuous s_valid. Output sequence must equal the no-stall reference, and m_* must be stable during stalls.
- frame_restart and rst mid-frame:
  - Assert frame_restart with the 5th sample. Expect that output tagged m_first with coefficient table[0].
  - Assert rst mid-stream. Expect m_valid low the next cycle and INIT restarted.
